sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Sequences the data-memory access of the pipelined ARM core onto an external 16-bit-wide asynchronous SRAM.
- Each 32-bit load/store from the MEM stage is split into two 16-bit SRAM phases (low half, then high half), each lasting a fixed number of wait cycles.
- The block drives `ready` low while an access is in progress; the top level ORs `~ready` into the pipeline freeze so every pipeline register holds its value until the access completes.

Parameters:
- WAIT_CYCLES, 5: cycles per 16-bit SRAM phase; legal range 1..15.
- ADDR_BASE, 1024: byte address mapped to SRAM word 0; subtracted from the incoming address.
- SRAM_AW, 18: SRAM address width in 16-bit half-words.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  store request from MEM stage; held stable while ready=0.
- rd_en  input  1  load request from MEM stage; held stable while ready=0.
- address  input  32  byte address (ALU result).
- write_data  input  32  store data (Rm value).
- read_data  output  32  load result; registered.
- ready  output  1  1 = no access in progress / access completing this cycle.
- sram_addr  output  SRAM_AW  half-word address to SRAM.
- sram_dq_out  output  16  data driven to SRAM during writes.
- sram_dq_oe  output  1  1 = drive sram_dq_out onto the SRAM bus (top-level tristate).
- sram_dq_in  input  16  data bus sampled from SRAM.
- sram_we_n  output  1  active-low SRAM write enable.

Behaviour:

States: IDLE, LOW, HIGH, DONE. There is one 4-bit phase counter.

Reset (synchronous, rst=1 at a rising edge):
- state=IDLE, counter=0, read_data=0, latched address/data/op = 0.
- Outputs: sram_we_n=1, sram_dq_oe=0, sram_addr=0.
- Takes priority over everything, including mid-access. The SRAM write strobe deasserts on the same edge, and a partially written word is left as is.

IDLE:
- ready = ~(wr_en | rd_en), combinational, so the freeze is asserted in the same cycle the request appears.
- On a request, latch:
  - op: write if wr_en=1; wr_en has priority if both are asserted.
  - word index = ((address - ADDR_BASE) mod 2^32) >> 2, truncated to SRAM_AW-1 bits; address[1:0] is ignored.
  - write_data.
- Then counter←0 and go to LOW.
- Outputs: sram_we_n=1, sram_dq_oe=0.

LOW:
- ready=0.
- sram_addr = {index, 1'b0}.
- Write: sram_dq_out = data[15:0], sram_dq_oe=1, sram_we_n=0.
- Read: sram_we_n=1, sram_dq_oe=0.
- counter increments each cycle. When counter==WAIT_CYCLES-1:
  - on a read, read_data[15:0] ← sram_dq_in;
  - counter←0, go to HIGH.

HIGH:
- Same as LOW, except sram_addr = {index, 1'b1} and the write data is data[31:16].
- On a read, the capture goes to read_data[31:16].
- At the terminal count, go to DONE.

DONE:
- ready=1, sram_we_n=1, sram_dq_oe=0.
- The pipeline advances on this edge.
- Go to IDLE unconditionally; the request seen in DONE is the one already served and is not restarted.

Timing:
- Latency: the request appears in cycle 0; ready is low for cycles 0..2·WAIT_CYCLES and high in cycle 2·WAIT_CYCLES+1.
- Default: 11 stalled cycles.

Data and request rules:
- read_data holds its value between reads; writes do not alter it.
- Request deassertion mid-access is ignored, and the access completes.
- Requests are sampled only in IDLE.
- Back-to-back requests: the next access starts in the IDLE cycle following DONE, with one ready=1 cycle between them.
- Address wrap: an address below ADDR_BASE wraps modulo 2^32. The upper bits are truncated, so the index wraps modulo 2^(SRAM_AW-1).
- sram_addr in IDLE/DONE: holds the last phase's address (don't-care to SRAM).

Test Plan:

The bench includes a 2^SRAM_AW × 16 behavioural SRAM model that writes on sram_we_n=0 and reads combinationally.

1. Reset, then idle with no requests → ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0.
2. wr_en=1, address=1028, write_data=0xDEADBEEF → ready low for exactly 11 cycles; SRAM[2]=0xBEEF, SRAM[3]=0xDEAD; ready=1 in cycle 11.
3. Then rd_en=1, address=1028 → after 11 stall cycles read_data=0xDEADBEEF. rd_en=0 for 5 cycles → read_data unchanged.
4. rd_en and wr_en both high, address=1032, write_data=0x12345678 → write performed; SRAM[4..5]=0x5678/0x1234; read_data unchanged.
5. Assert rst during HIGH of a write of 0xCAFEF00D to 1036 → next cycle: state IDLE, sram_we_n=1, ready=1; SRAM[6]=0xF00D; a following read completes normally.
6. WAIT_CYCLES=1: back-to-back writes to 1024 and 1028 (request held continuously) → each takes 3 stall cycles, with one ready=1 cycle between them; a readback of both is correct.

Source files
------------

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM phases of
// WAIT_CYCLES each, and holds the pipeline through ready=0.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t             state_r, state_s;
  logic [3:0]         count_r;
  logic [SRAM_AW-2:0] index_r;
  logic               phase_r;
  logic [31:0]        data_r;
  logic               op_wr_r;
  logic [31:0]        offset_s;
  logic               req_s;
  logic               terminal_s;
  logic               unused_s;

  // Request decode and SRAM word offset (wraps modulo 2^32 below ADDR_BASE)
  always_comb begin
    offset_s   = address - ADDR_BASE;
    req_s      = wr_en | rd_en;
    terminal_s = (count_r == LAST_CNT);
    unused_s   = ^{offset_s[31:SRAM_AW+1], offset_s[1:0]};
  end

  // The phase bit keeps the last driven half-word address visible in IDLE/DONE
  assign sram_addr = {index_r, phase_r};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and SRAM strobes; IDLE ready is combinational so the freeze
  // lands in the same cycle the request appears
  always_comb begin
    state_s     = state_r;
    ready       = 1'b1;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = 16'h0000;
    case (state_r)
      IDLE: begin
        ready = ~req_s;
        if (req_s) begin
          state_s = LOW;
        end else begin
          state_s = IDLE;
        end
      end
      LOW, HIGH: begin
        ready       = 1'b0;
        sram_dq_out = (state_r == HIGH) ? data_r[31:16] : data_r[15:0];
        if (op_wr_r) begin
          sram_dq_oe = 1'b1;
          sram_we_n  = 1'b0;
        end else begin
          sram_dq_oe = 1'b0;
          sram_we_n  = 1'b1;
        end
        if (terminal_s) begin
          state_s = (state_r == HIGH) ? DONE : HIGH;
        end else begin
          state_s = state_r;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_s = IDLE;
      end
      default: begin
        ready   = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // Request latch, phase counter and read capture
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r   <= 4'd0;
      read_data <= 32'h0000_0000;
      index_r   <= '0;
      phase_r   <= 1'b0;
      data_r    <= 32'h0000_0000;
      op_wr_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            op_wr_r <= wr_en;
            index_r <= offset_s[SRAM_AW:2];
            data_r  <= write_data;
            count_r <= 4'd0;
            phase_r <= 1'b0;
          end
        end
        LOW: begin
          if (terminal_s) begin
            count_r <= 4'd0;
            phase_r <= 1'b1;
            if (!op_wr_r) begin
              read_data[15:0] <= sram_dq_in;
            end
          end else begin
            count_r <= count_r + 4'd1;
          end
        end
        HIGH: begin
          if (terminal_s) begin
            count_r <= 4'd0;
            if (!op_wr_r) begin
              read_data[31:16] <= sram_dq_in;
            end
          end else begin
            count_r <= count_r + 4'd1;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: a WAIT_CYCLES=5 instance driven from a
// vector table plus hand sequences, and a WAIT_CYCLES=1 instance for back-to-back.
module tb_sram_controller;

  localparam int MEMSZ = 262144;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wr1, rd1, wr2, rd2;
  logic [31:0] addr1, wd1, addr2, wd2;
  logic [31:0] rdata1, rdata2;
  logic        ready1, ready2, oe1, oe2, we1_n, we2_n;
  logic [17:0] saddr1, saddr2;
  logic [15:0] dqo1, dqo2, dqi1, dqi2;

  logic [15:0] mem1 [0:MEMSZ-1];
  logic [15:0] mem2 [0:MEMSZ-1];

  sram_controller #(.WAIT_CYCLES(5), .ADDR_BASE(32'd1024), .SRAM_AW(18)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(addr1),
    .write_data(wd1), .read_data(rdata1), .ready(ready1), .sram_addr(saddr1),
    .sram_dq_out(dqo1), .sram_dq_oe(oe1), .sram_dq_in(dqi1), .sram_we_n(we1_n));

  sram_controller #(.WAIT_CYCLES(1), .ADDR_BASE(32'd1024), .SRAM_AW(18)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr2), .rd_en(rd2), .address(addr2),
    .write_data(wd2), .read_data(rdata2), .ready(ready2), .sram_addr(saddr2),
    .sram_dq_out(dqo2), .sram_dq_oe(oe2), .sram_dq_in(dqi2), .sram_we_n(we2_n));

  // Behavioural SRAMs: write while we_n is low, combinational read
  always @(posedge clk) begin
    if (!we1_n) mem1[saddr1] <= dqo1;
    if (!we2_n) mem2[saddr2] <= dqo2;
  end
  assign dqi1 = mem1[saddr1];
  assign dqi2 = mem2[saddr2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one access, count ready-low cycles, drop the request in the DONE cycle
  task automatic run_access(input bit sel, input logic wr, input logic rd,
                            input logic [31:0] a, input logic [31:0] d,
                            input int exp_stalls, input string name);
    int stalls;
    bit done;
    @(posedge clk);
    #1;
    if (sel) begin
      wr2 = wr; rd2 = rd; addr2 = a; wd2 = d;
    end else begin
      wr1 = wr; rd1 = rd; addr1 = a; wd1 = d;
    end
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if ((sel ? ready2 : ready1) == 1'b1) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    wr1 = 1'b0; rd1 = 1'b0; wr2 = 1'b0; rd2 = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s timeout: ready still low after 100 cycles", name);
    end else begin
      chk({name, " stalls"}, 32'(stalls), 32'(exp_stalls));
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [9];
  logic [7:0] exp_pat;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'd1028,   32'hDEADBEEF, 32'h0000_0000};
    vecs[1] = '{1'b0, 1'b1, 32'd1028,   32'h0000_0000, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'd1032,   32'h12345678, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1032,   32'h0000_0000, 32'h12345678};
    vecs[4] = '{1'b0, 1'b1, 32'd1031,   32'h0000_0000, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 32'd1020,   32'hA5A55A5A, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 1'b1, 32'd525308, 32'h0000_0000, 32'hA5A55A5A};
    vecs[7] = '{1'b1, 1'b0, 32'd1024,   32'h0F0F0F0F, 32'hA5A55A5A};
    vecs[8] = '{1'b0, 1'b1, 32'd1024,   32'h0000_0000, 32'h0F0F0F0F};

    for (int i = 0; i < MEMSZ; i++) begin
      mem1[i] = 16'h0000;
      mem2[i] = 16'h0000;
    end
    rst = 1'b1;
    wr1 = 1'b0; rd1 = 1'b0; addr1 = 32'h0; wd1 = 32'h0;
    wr2 = 1'b0; rd2 = 1'b0; addr2 = 32'h0; wd2 = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset ready", 32'(ready1), 32'd1);
    chk("reset we_n", 32'(we1_n), 32'd1);
    chk("reset oe", 32'(oe1), 32'd0);
    chk("reset read_data", rdata1, 32'h0000_0000);

    for (int i = 0; i < 9; i++) begin
      run_access(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, 11,
                 $sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d read_data", i), rdata1, vecs[i].exp_rd);
    end

    chk("mem[2]", 32'(mem1[2]), 32'h0000BEEF);
    chk("mem[3]", 32'(mem1[3]), 32'h0000DEAD);
    chk("mem[4]", 32'(mem1[4]), 32'h00005678);
    chk("mem[5]", 32'(mem1[5]), 32'h00001234);
    chk("mem wrap lo", 32'(mem1[262142]), 32'h00005A5A);
    chk("mem wrap hi", 32'(mem1[262143]), 32'h0000A5A5);

    repeat (5) @(negedge clk);
    chk("idle hold read_data", rdata1, 32'h0F0F0F0F);
    chk("idle ready", 32'(ready1), 32'd1);

    // Reset in the middle of the HIGH phase of a write
    @(posedge clk);
    #1 wr1 = 1'b1; addr1 = 32'd1036; wd1 = 32'hCAFEF00D;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1; wr1 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post-reset we_n", 32'(we1_n), 32'd1);
    chk("post-reset ready", 32'(ready1), 32'd1);
    chk("post-reset oe", 32'(oe1), 32'd0);
    chk("post-reset read_data", rdata1, 32'h0000_0000);
    chk("post-reset mem[6]", 32'(mem1[6]), 32'h0000F00D);
    run_access(1'b0, 1'b0, 1'b1, 32'd1036, 32'h0, 11, "read after reset");
    @(negedge clk);
    chk("read after reset data", rdata1, 32'hCAFEF00D);

    // Back-to-back writes with the request held, WAIT_CYCLES=1
    exp_pat = 8'b1000_1000;
    @(posedge clk);
    #1 wr2 = 1'b1; addr2 = 32'd1024; wd2 = 32'h11112222;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("b2b ready cycle %0d", c), 32'(ready2), 32'(exp_pat[c]));
      if (c == 3) begin
        addr2 = 32'd1028;
        wd2   = 32'h33334444;
      end
      if (c == 7) wr2 = 1'b0;
    end
    run_access(1'b1, 1'b0, 1'b1, 32'd1024, 32'h0, 3, "b2b read0");
    @(negedge clk);
    chk("b2b read0 data", rdata2, 32'h11112222);
    run_access(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0, 3, "b2b read1");
    @(negedge clk);
    chk("b2b read1 data", rdata2, 32'h33334444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
